// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: packs a byte stream two bytes per word,
// writes consecutive addresses from 0, and releases the core hold once the load completes.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 9,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_hold
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};

  // High-byte bits above the instruction width must be zero; none exist at width 16.
  function automatic logic hi_unused_set(input logic [7:0] b);
    logic [7:0] mask;
    mask = 8'hFF << (DATA_WIDTH - 8);
    return |(b & mask);
  endfunction

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH:0]     len_r, len_s;
  logic [ADDR_WIDTH-1:0]   count_r, count_s;
  logic [7:0]              lo_byte_r, lo_byte_s;
  logic                    wr_en_r, wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_r, wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_r, wr_data_s;
  logic                    done_r, done_s;
  logic                    error_r, error_s;
  logic                    hold_r, hold_s;
  logic                    in_ready_r, in_ready_s;
  logic                    busy_r, busy_s;
  logic                    len_ok_s;
  logic                    last_s;

  assign len_ok_s = (len != LEN_ZERO) && (len <= DEPTH_W);
  assign last_s   = ({1'b0, count_r} == (len_r - LEN_ONE));

  // Next-state and next-output decode for the load sequencer.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    count_s   = count_r;
    lo_byte_s = lo_byte_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    error_s   = error_r;
    hold_s    = hold_r;
    case (state_r)
      IDLE: begin
        if (start && len_ok_s) begin
          len_s   = len;
          count_s = CNT_ZERO;
          error_s = 1'b0;
          hold_s  = 1'b1;
          state_s = LO;
        end else if (start) begin
          error_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LO: begin
        if (in_valid) begin
          lo_byte_s = in_data;
          state_s   = HI;
        end else begin
          state_s = LO;
        end
      end
      HI: begin
        if (in_valid && hi_unused_set(in_data)) begin
          error_s = 1'b1;
          state_s = IDLE;
        end else if (in_valid) begin
          wr_en_s   = 1'b1;
          wr_addr_s = count_r;
          wr_data_s = DATA_WIDTH'({in_data, lo_byte_r});
          state_s   = WR;
        end else begin
          state_s = HI;
        end
      end
      WR: begin
        if (last_s) begin
          hold_s  = 1'b0;
          state_s = FIN;
        end else begin
          count_s = count_r + CNT_ONE;
          state_s = LO;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    done_s     = (state_s == FIN);
    in_ready_s = (state_s == LO) || (state_s == HI);
    busy_s     = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      len_r      <= LEN_ZERO;
      count_r    <= CNT_ZERO;
      lo_byte_r  <= 8'h00;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= CNT_ZERO;
      wr_data_r  <= {DATA_WIDTH{1'b0}};
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      hold_r     <= 1'b1;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      count_r    <= count_s;
      lo_byte_r  <= lo_byte_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      done_r     <= done_s;
      error_r    <= error_s;
      hold_r     <= hold_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign core_hold = hold_r;

endmodule
